// File: rtl/imm_decode_unit_pkg.sv
// Shared types for the immediate decode unit: immediate format enum,
// base-ISA opcode values and the output FIFO entry layout.
// Optional feature macro used by this slice: IMMGEN_RVC_EN (compressed decode).
package imm_pkg;

  // Widest supported immediate; FIFO entries always carry this many bits.
  localparam int IMM_MAX_W = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CI   = 3'd6,
    IMM_CJ   = 3'd7
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_type_e            imm_type;
    logic                 illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode_unit_if.sv
// Instruction-in / immediate-out handshake bundle of the decode unit.
// The producer/consumer side uses modport master, the unit uses slave.
interface imm_decode_unit_if #(
  parameter int XLEN = 32
) ();
  import imm_pkg::*;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_inst_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_imm_o;
  imm_type_e       out_type_o;
  logic            out_illegal_o;

  modport master (
    output in_valid_i, in_inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_imm_o, out_type_o, out_illegal_o
  );

  modport slave (
    input  in_valid_i, in_inst_i, out_ready_i,
    output in_ready_o, out_valid_o, out_imm_o, out_type_o, out_illegal_o
  );
endinterface

// File: rtl/imm_decode_unit_comb.sv
// Pure combinational immediate decoder (module imm_decode_comb).
// Compressed encodings are decoded only when IMMGEN_RVC_EN is defined;
// otherwise every non-32-bit encoding is flagged illegal.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  // Select the immediate format from the opcode and sign-extend the field.
  always_comb begin
    imm_o      = '0;
    imm_type_o = IMM_NONE;
    illegal_o  = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      case (inst_i[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          imm_type_o = IMM_I;
          imm_o      = XLEN'(signed'(inst_i[31:20]));
        end
        OPC_STORE: begin
          imm_type_o = IMM_S;
          imm_o      = XLEN'(signed'({inst_i[31:25], inst_i[11:7]}));
        end
        OPC_BRANCH: begin
          imm_type_o = IMM_B;
          imm_o      = XLEN'(signed'({inst_i[31], inst_i[7], inst_i[30:25],
                                      inst_i[11:8], 1'b0}));
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_type_o = IMM_U;
          imm_o      = XLEN'(signed'({inst_i[31:12], 12'h000}));
        end
        OPC_JAL: begin
          imm_type_o = IMM_J;
          imm_o      = XLEN'(signed'({inst_i[31], inst_i[19:12], inst_i[20],
                                      inst_i[30:21], 1'b0}));
        end
        OPC_OP: begin
          imm_type_o = IMM_NONE;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end else begin
`ifdef IMMGEN_RVC_EN
      // Quadrant 1: C.ADDI (000), C.LI (010), C.J (101).
      if (inst_i[1:0] == 2'b01 &&
          (inst_i[15:13] == 3'b000 || inst_i[15:13] == 3'b010)) begin
        imm_type_o = IMM_CI;
        imm_o      = XLEN'(signed'({inst_i[12], inst_i[6:2]}));
      end else if (inst_i[1:0] == 2'b01 && inst_i[15:13] == 3'b101) begin
        imm_type_o = IMM_CJ;
        imm_o      = XLEN'(signed'({inst_i[12], inst_i[8], inst_i[10:9],
                                    inst_i[6], inst_i[7], inst_i[2],
                                    inst_i[11], inst_i[5:3], 1'b0}));
      end else begin
        illegal_o = 1'b1;
      end
`else
      illegal_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/imm_decode_unit.sv
// Immediate decode unit: combinational decode feeding a 2-entry output
// FIFO, plus a saturating count of accepted illegal instructions.
// Optional macro IMMGEN_RVC_EN enables compressed decode in imm_decode_comb.
module imm_decode_unit
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  imm_decode_unit_if.slave bus,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_decode_unit: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm_s;
  imm_type_e        dec_type_s;
  logic             dec_illegal_s;
  imm_entry_t       entry_s;
  imm_entry_t       mem_r [2];
  logic [1:0]       count_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] illegal_cnt_r;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i     (bus.in_inst_i),
    .imm_o      (dec_imm_s),
    .imm_type_o (dec_type_s),
    .illegal_o  (dec_illegal_s)
  );

  // Pack the decode result into a FIFO entry (imm widened by sign).
  always_comb begin
    entry_s.imm      = IMM_MAX_W'(signed'(dec_imm_s));
    entry_s.imm_type = dec_type_s;
    entry_s.illegal  = dec_illegal_s;
  end

  // Ready/valid come only from the registered occupancy.
  assign bus.in_ready_o  = (count_r != 2'd2);
  assign bus.out_valid_o = (count_r != 2'd0);
  assign push_s          = bus.in_valid_i && bus.in_ready_o;
  assign pop_s           = bus.out_valid_o && bus.out_ready_i;

  assign bus.out_imm_o     = mem_r[rd_ptr_r].imm[XLEN-1:0];
  assign bus.out_type_o    = mem_r[rd_ptr_r].imm_type;
  assign bus.out_illegal_o = mem_r[rd_ptr_r].illegal;
  assign illegal_cnt_o     = illegal_cnt_r;

  // FIFO storage; contents need no reset since valid gates them.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else if (flush_i) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating illegal-instruction counter; unaffected by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_r <= '0;
    end else if (push_s && dec_illegal_s && (illegal_cnt_r != '1)) begin
      illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

endmodule

// File: tb/tb_imm_decode_unit.sv
// Self-checking bench: two units (XLEN=32/CNT_W=4 and XLEN=64/CNT_W=16)
// driven by the same stimulus and compared against a queue-based model.
module tb_imm_decode_unit;

  localparam int T_NONE = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5, T_CI = 6, T_CJ = 7;

  typedef struct {
    longint imm;
    int     ty;
    bit     ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic        out_ready = 1'b0;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t q[$];
  int   cnt_a_m = 0;
  int   cnt_b_m = 0;

  imm_decode_unit_if #(.XLEN(32)) if_a ();
  imm_decode_unit_if #(.XLEN(64)) if_b ();

  assign if_a.in_valid_i  = in_valid;
  assign if_a.in_inst_i   = in_inst;
  assign if_a.out_ready_i = out_ready;
  assign if_b.in_valid_i  = in_valid;
  assign if_b.in_inst_i   = in_inst;
  assign if_b.out_ready_i = out_ready;

  imm_decode_unit #(.XLEN(32), .CNT_W(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if_a.slave), .illegal_cnt_o(cnt_a)
  );
  imm_decode_unit #(.XLEN(64), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if_b.slave), .illegal_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint m;
    m = longint'(1) << bits;
    v = v & (m - 1);
    if (v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  // Reference decode, built from the instruction-format field layouts.
  function automatic void ref_decode(input logic [31:0] inst, output longint imm,
                                     output int ty, output bit ill);
    longint u;
    longint opc;
    longint q2;
    longint f3;
    u   = longint'(inst);
    opc = u & 127;
    q2  = u & 3;
    f3  = (u >> 13) & 7;
    imm = 0; ty = T_NONE; ill = 1'b0;
    if (q2 == 3) begin
      case (opc)
        'h13, 'h03, 'h67: begin ty = T_I; imm = sext(u >> 20, 12); end
        'h23: begin ty = T_S; imm = sext(((u >> 25) << 5) + ((u >> 7) & 31), 12); end
        'h63: begin
          ty  = T_B;
          imm = sext(((u >> 31) << 12) + (((u >> 7) & 1) << 11) + (((u >> 25) & 63) << 5)
                     + (((u >> 8) & 15) << 1), 13);
        end
        'h37, 'h17: begin ty = T_U; imm = sext(u & 'hFFFFF000, 32); end
        'h6F: begin
          ty  = T_J;
          imm = sext(((u >> 31) << 20) + (((u >> 12) & 255) << 12) + (((u >> 20) & 1) << 11)
                     + (((u >> 21) & 1023) << 1), 21);
        end
        'h33: ty = T_NONE;
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef IMMGEN_RVC_EN
      if (q2 == 1 && (f3 == 0 || f3 == 2)) begin
        ty  = T_CI;
        imm = sext((((u >> 12) & 1) << 5) + ((u >> 2) & 31), 6);
      end else if (q2 == 1 && f3 == 5) begin
        ty  = T_CJ;
        imm = sext((((u >> 12) & 1) << 11) + (((u >> 8) & 1) << 10) + (((u >> 9) & 3) << 8)
                   + (((u >> 6) & 1) << 7) + (((u >> 7) & 1) << 6) + (((u >> 2) & 1) << 5)
                   + (((u >> 11) & 1) << 4) + (((u >> 3) & 7) << 1), 12);
      end else begin
        ill = 1'b1;
      end
`else
      ill = 1'b1;
`endif
    end
  endfunction

  // One clock: check both units against the model, then advance the model.
  task automatic step();
    exp_t e;
    bit   acc;
    bit   pop;
    @(negedge clk);
    check_eq("a_valid", 64'(if_a.out_valid_o), 64'(q.size() != 0));
    check_eq("b_valid", 64'(if_b.out_valid_o), 64'(q.size() != 0));
    check_eq("a_ready", 64'(if_a.in_ready_o), 64'(q.size() < 2));
    check_eq("b_ready", 64'(if_b.in_ready_o), 64'(q.size() < 2));
    check_eq("a_cnt", 64'(cnt_a), 64'(cnt_a_m));
    check_eq("b_cnt", 64'(cnt_b), 64'(cnt_b_m));
    if (q.size() != 0) begin
      check_eq("a_imm", {32'h0, if_a.out_imm_o}, q[0].imm & 64'hFFFF_FFFF);
      check_eq("b_imm", if_b.out_imm_o, q[0].imm);
      check_eq("a_type", 64'(if_a.out_type_o), 64'(q[0].ty));
      check_eq("b_type", 64'(if_b.out_type_o), 64'(q[0].ty));
      check_eq("a_ill", 64'(if_a.out_illegal_o), 64'(q[0].ill));
      check_eq("b_ill", 64'(if_b.out_illegal_o), 64'(q[0].ill));
    end
    acc = in_valid && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    ref_decode(in_inst, e.imm, e.ty, e.ill);
    @(posedge clk);
    #1;
    if (acc && e.ill) begin
      if (cnt_a_m < 15) cnt_a_m++;
      if (cnt_b_m < 65535) cnt_b_m++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic push(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          sel;
    logic [6:0]  opcs [9];
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r    = $urandom();
    sel  = $urandom_range(0, 11);
    if (sel < 9) r[6:0] = opcs[sel];
    else if (sel == 9) r[1:0] = 2'b11;
    else if (sel == 10) r[1:0] = 2'($urandom_range(0, 2));
    else r[1:0] = 2'b01;
    return r;
  endfunction

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_a_valid", 64'(if_a.out_valid_o), 64'd0);
    check_eq("rst_b_valid", 64'(if_b.out_valid_o), 64'd0);
    check_eq("rst_a_cnt", 64'(cnt_a), 64'd0);
    check_eq("rst_b_cnt", 64'(cnt_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_a_ready", 64'(if_a.in_ready_o), 64'd1);

    // addi x1,x0,-1 with consumer ready.
    out_ready = 1'b1;
    push(32'hFFF00093);
    check_eq("addi_valid", 64'(if_a.out_valid_o), 64'd1);
    check_eq("addi_imm32", 64'(if_a.out_imm_o), 64'hFFFF_FFFF);
    check_eq("addi_type", 64'(if_a.out_type_o), 64'(T_I));

    // lui / jal at XLEN=64.
    push(32'h80000037);
    check_eq("lui_imm64", if_b.out_imm_o, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui_type", 64'(if_b.out_type_o), 64'(T_U));
    push(32'hFFDFF06F);
    check_eq("jal_imm64", if_b.out_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("jal_type", 64'(if_b.out_type_o), 64'(T_J));

    // Illegal opcode and counter saturation on the 4-bit counter.
    push(32'h0000007F);
    check_eq("ill_flag", 64'(if_b.out_illegal_o), 64'd1);
    check_eq("ill_imm", if_b.out_imm_o, 64'd0);
    check_eq("ill_cnt", 64'(cnt_b), 64'd1);
    for (int i = 0; i < 16; i++) push(32'h0000007F);
    check_eq("cnt_sat", 64'(cnt_a), 64'hF);
    push(32'h0000007F);
    check_eq("cnt_sat_hold", 64'(cnt_a), 64'hF);
    step();
    step();

    // Back-pressure: three offered, two taken, then all emerge in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00500113; step();
    in_inst   = 32'hFE208EE3; step();
    check_eq("full_ready", 64'(if_a.in_ready_o), 64'd0);
    in_inst   = 32'h00112623; step();
    out_ready = 1'b1;
    step();
    step();
    in_valid  = 1'b0;
    repeat (3) step();

    // Flush while full with a pending input.
    out_ready = 1'b0;
    push(32'h00000013);
    push(32'h00000017);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000007F;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", 64'(if_a.out_valid_o), 64'd0);
    check_eq("flush_cnt", 64'(cnt_b), 64'(cnt_b_m));
    step();

    // Asynchronous reset in the middle of a stall.
    push(32'h12345037);
    push(32'h00A00093);
    rst_n = 1'b0;
    #1;
    check_eq("arst_a_valid", 64'(if_a.out_valid_o), 64'd0);
    check_eq("arst_b_valid", 64'(if_b.out_valid_o), 64'd0);
    check_eq("arst_cnt", 64'(cnt_b), 64'd0);
    q.delete(); cnt_a_m = 0; cnt_b_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Compressed c.addi x0,-1.
    out_ready = 1'b1;
    push(32'h0000107D);
`ifdef IMMGEN_RVC_EN
    check_eq("rvc_type", 64'(if_b.out_type_o), 64'(T_CI));
    check_eq("rvc_imm", if_b.out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check_eq("rvc_ill", 64'(if_b.out_illegal_o), 64'd1);
    check_eq("rvc_imm", if_b.out_imm_o, 64'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = flush ? 1'b0 : 1'($urandom_range(0, 1));
      in_inst   = rand_inst();
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
